// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU request sequencer.
//   alu_req_t   : one queued ALU operation (operands, carry, mode, command, operand-valid code)
//   alu_rsp_t   : one captured ALU result (RES, flags {COUT,OFLOW,G,E,L,ERR}, command)
//   seq_state_e : issue FSM states
// The struct fields are sized from SEQ_WIDTH/SEQ_CMD_W; the top-level WIDTH/CMD_W
// parameters must match these.
package alu_seq_pkg;

  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_CMD_W = 4;

  localparam logic [SEQ_CMD_W-1:0] CMD_MUL_INC   = 4'd9;
  localparam logic [SEQ_CMD_W-1:0] CMD_MUL_SHIFT = 4'd10;

  typedef struct packed {
    logic [SEQ_WIDTH-1:0] opa;
    logic [SEQ_WIDTH-1:0] opb;
    logic                 cin;
    logic                 mode;
    logic [SEQ_CMD_W-1:0] cmd;
    logic [1:0]           inp_valid;
  } alu_req_t;

  typedef struct packed {
    logic [SEQ_WIDTH:0]   res;
    logic [5:0]           flags;
    logic [SEQ_CMD_W-1:0] cmd;
  } alu_rsp_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_RESP
  } seq_state_e;

  // Multiplies take the longer ALU latency.
  function automatic logic is_mul(input logic mode, input logic [SEQ_CMD_W-1:0] cmd);
    return mode && ((cmd == CMD_MUL_INC) || (cmd == CMD_MUL_SHIFT));
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO of alu_req_t.
//   CLK, RST   : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write one entry (ignored when full)
//   pop/rdata  : rdata shows the head; pop removes it (ignored when empty)
//   full/empty : occupancy status
//   level      : number of stored entries, 0..DEPTH
module alu_req_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  alu_req_t                 wdata,
  input  logic                     pop,
  output alu_req_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  alu_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset; level gates every read.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_req_sequencer.sv
// Issue stage in front of ALU_DESIGN: queues requests, issues one op at a time,
// waits the command-dependent latency and holds the result on a valid/ready port.
//   CLK, RST                 : clock, asynchronous active-low reset
//   req_*                    : valid/ready request port (operands, carry, mode, cmd, inp_valid)
//   OPA..CMD                 : ALU input pins
//   RES, COUT..ERR           : ALU result pins
//   rsp_*                    : valid/ready response port (res, flags {COUT,OFLOW,G,E,L,ERR}, cmd)
//   level                    : request FIFO occupancy
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no op in flight; pop FIFO head into issue register if present
// S_ISSUE | drive ALU pins with CE=1, load latency down-counter
// S_WAIT  | hold pins with CE=1 until the counter reaches terminal count
// S_CAPT  | CE=0, capture RES and flags into response register
// S_RESP  | hold response until the consumer accepts it
module alu_req_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = SEQ_WIDTH,
  parameter int CMD_W   = SEQ_CMD_W,
  parameter int DEPTH   = 4,
  parameter int LAT     = 1,
  parameter int MUL_LAT = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_opa,
  input  logic [WIDTH-1:0]       req_opb,
  input  logic                   req_cin,
  input  logic                   req_mode,
  input  logic [CMD_W-1:0]       req_cmd,
  input  logic [1:0]             req_inp_valid,
  output logic [WIDTH-1:0]       OPA,
  output logic [WIDTH-1:0]       OPB,
  output logic                   CIN,
  output logic                   CE,
  output logic                   MODE,
  output logic [1:0]             INP_VALID,
  output logic [CMD_W-1:0]       CMD,
  input  logic [WIDTH:0]         RES,
  input  logic                   COUT,
  input  logic                   OFLOW,
  input  logic                   G,
  input  logic                   E,
  input  logic                   L,
  input  logic                   ERR,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH:0]         rsp_res,
  output logic [5:0]             rsp_flags,
  output logic [CMD_W-1:0]       rsp_cmd,
  output logic [$clog2(DEPTH):0] level
);

  localparam int MAX_LAT = (LAT > MUL_LAT) ? LAT : MUL_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) + 1 : 1;
  localparam logic [CNT_W-1:0] LAT_LD = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);

  seq_state_e       state, state_nxt;
  alu_req_t         req_in;
  alu_req_t         head;
  alu_req_t         iss_q;
  alu_rsp_t         rsp_q;
  logic             rsp_valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_ld;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             rdy_en;

  assign req_in = '{opa: req_opa, opb: req_opb, cin: req_cin, mode: req_mode,
                    cmd: req_cmd, inp_valid: req_inp_valid};

  // rdy_en keeps req_ready low during reset and for the cycle before the first edge.
  assign req_ready = rdy_en && !fifo_full;

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (req_valid && req_ready),
    .wdata (req_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign cnt_ld = is_mul(iss_q.mode, iss_q.cmd) ? MUL_LD : LAT_LD;

  // Operand pins come straight from the issue register so they hold their
  // last values between ops and clear on reset.
  assign OPA       = iss_q.opa;
  assign OPB       = iss_q.opb;
  assign CIN       = iss_q.cin;
  assign MODE      = iss_q.mode;
  assign CMD       = iss_q.cmd;
  assign INP_VALID = iss_q.inp_valid;

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_q.res;
  assign rsp_flags = rsp_q.flags;
  assign rsp_cmd   = rsp_q.cmd;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    CE        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        CE        = 1'b1;
        state_nxt = (cnt_ld == '0) ? S_CAPT : S_WAIT;
      end
      S_WAIT: begin
        CE = 1'b1;
        if (cnt_q == CNT_W'(1)) state_nxt = S_CAPT;
      end
      S_CAPT: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      iss_q       <= '0;
      cnt_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdy_en      <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      state  <= state_nxt;
      if (pop) iss_q <= head;
      if (state == S_ISSUE)     cnt_q <= cnt_ld;
      else if (state == S_WAIT) cnt_q <= cnt_q - 1'b1;
      if (state == S_CAPT) begin
        rsp_q.res   <= RES;
        rsp_q.flags <= {COUT, OFLOW, G, E, L, ERR};
        rsp_q.cmd   <= iss_q.cmd;
        rsp_valid_q <= 1'b1;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_req_sequencer.sv
module tb_alu_req_sequencer;
  import alu_seq_pkg::*;

  localparam int WIDTH   = 8;
  localparam int CMD_W   = 4;
  localparam int DEPTH   = 4;
  localparam int LAT     = 1;
  localparam int MUL_LAT = 2;
  localparam int PERIOD  = 10;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [WIDTH-1:0] req_opa = '0, req_opb = '0;
  logic req_cin = 1'b0, req_mode = 1'b0;
  logic [CMD_W-1:0] req_cmd = '0;
  logic [1:0] req_inp_valid = '0;
  logic [WIDTH-1:0] OPA, OPB;
  logic CIN, CE, MODE;
  logic [1:0] INP_VALID;
  logic [CMD_W-1:0] CMD;
  logic [WIDTH:0] RES;
  logic COUT, OFLOW, G, E, L, ERR;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [WIDTH:0] rsp_res;
  logic [5:0] rsp_flags;
  logic [CMD_W-1:0] rsp_cmd;
  logic [$clog2(DEPTH):0] level;

  int n_checks = 0;
  int n_fail   = 0;
  alu_rsp_t sb[$];

  always #(PERIOD/2) CLK = ~CLK;

  alu_req_sequencer #(.WIDTH(WIDTH), .CMD_W(CMD_W), .DEPTH(DEPTH), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin), .req_mode(req_mode),
    .req_cmd(req_cmd), .req_inp_valid(req_inp_valid),
    .OPA(OPA), .OPB(OPB), .CIN(CIN), .CE(CE), .MODE(MODE), .INP_VALID(INP_VALID), .CMD(CMD),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .rsp_cmd(rsp_cmd), .level(level)
  );

  // Reference ALU behaviour for the commands used here.
  function automatic logic [WIDTH:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic mode, input logic [3:0] cmd);
    logic [17:0] p;
    if (mode) begin
      case (cmd)
        4'd0:  return {1'b0, a} + {1'b0, b};
        4'd1:  return {1'b0, a} - {1'b0, b};
        4'd2:  return {1'b0, a} + {1'b0, b} + {8'b0, cin};
        4'd9:  begin p = ({10'b0, a} + 18'd1) * ({10'b0, b} + 18'd1); return p[8:0]; end
        4'd10: begin p = {9'b0, a, 1'b0} * {10'b0, b}; return p[8:0]; end
        default: return {1'b0, a} + {1'b0, b};
      endcase
    end else begin
      case (cmd)
        4'd0:    return {1'b0, a & b};
        4'd1:    return {1'b0, a | b};
        default: return {1'b0, a ^ b};
      endcase
    end
  endfunction

  // Behavioural ALU: registers a result on every edge where CE is high.
  logic [WIDTH:0] alu_res;
  logic alu_err;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_res <= '0;
      alu_err <= 1'b0;
    end else if (CE) begin
      alu_res <= ref_res(OPA, OPB, CIN, MODE, CMD);
      alu_err <= (INP_VALID == 2'b00);
    end
  end
  assign RES   = alu_res;
  assign COUT  = alu_res[WIDTH];
  assign OFLOW = 1'b0;
  assign G     = 1'b0;
  assign E     = 1'b0;
  assign L     = 1'b0;
  assign ERR   = alu_err;

  // Drive one request and hold it until accepted; pushes the expected response.
  task automatic push_req(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic mode, input logic [3:0] cmd, input logic [1:0] iv);
    alu_rsp_t e;
    int budget;
    req_valid = 1'b1; req_opa = a; req_opb = b; req_cin = cin;
    req_mode = mode; req_cmd = cmd; req_inp_valid = iv;
    budget = 0;
    @(negedge CLK);
    while (!req_ready && budget < 200) begin
      @(negedge CLK);
      budget++;
    end
    n_checks++;
    if (!req_ready) begin
      n_fail++;
      $display("FAIL push_accept req_ready=%b required 1 within 200 cycles", req_ready);
    end else begin
      e.res   = ref_res(a, b, cin, mode, cmd);
      e.flags = {e.res[WIDTH], 4'b0000, (iv == 2'b00)};
      e.cmd   = cmd;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for a response handshake; returns what the DUT presented.
  task automatic get_rsp(output bit ok, output alu_rsp_t got);
    ok = 1'b0;
    got = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1;
        got = '{res: rsp_res, flags: rsp_flags, cmd: rsp_cmd};
      end
    end
    if (ok) begin @(posedge CLK); #1; end
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({OPA, OPB, CIN, CE, MODE, INP_VALID, CMD, rsp_valid, rsp_res, rsp_flags, rsp_cmd, level, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required all zero", {OPA, OPB, CIN, CE, MODE, INP_VALID, CMD,
               rsp_valid, rsp_res, rsp_flags, rsp_cmd, level, req_ready});
    end
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (req_ready !== 1'b1 || level !== '0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release req_ready=%b level=%0d rsp_valid=%b required 1 0 0", req_ready, level, rsp_valid);
    end
  endtask

  // Single op on an idle sequencer: pin values, CE width, response timing and data.
  task automatic test_single_op(input string name, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic mode, input logic [3:0] cmd,
                                input logic [1:0] iv, input int lat);
    int ce_cnt, ce_rises, first_k, valid_cycles;
    bit seen, ce_prev, pins_ok, pins_seen;
    alu_rsp_t got, exp;
    ce_cnt = 0; ce_rises = 0; first_k = 0; valid_cycles = 0;
    seen = 0; ce_prev = 0; pins_ok = 0; pins_seen = 0; got = '0;
    rsp_ready = 1'b1;
    push_req(a, b, cin, mode, cmd, iv);
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (CE && !ce_prev) ce_rises++;
      ce_prev = CE;
      if (CE && !pins_seen) begin
        pins_seen = 1;
        pins_ok = ({OPA, OPB, CIN, MODE, CMD, INP_VALID} === {a, b, cin, mode, cmd, iv});
      end
      if (rsp_valid) valid_cycles++;
      if (!seen) begin
        if (CE) ce_cnt++;
        if (rsp_valid) begin
          seen = 1;
          first_k = k;
          got = '{res: rsp_res, flags: rsp_flags, cmd: rsp_cmd};
        end
      end
    end
    @(posedge CLK); #1;
    n_checks++;
    if (!pins_ok) begin
      n_fail++;
      $display("FAIL %s_pins got %h required %h", name, {OPA, OPB, CIN, MODE, CMD, INP_VALID}, {a, b, cin, mode, cmd, iv});
    end
    n_checks++;
    if (ce_cnt != lat || ce_rises != 1) begin
      n_fail++;
      $display("FAIL %s_ce ce_cycles=%0d pulses=%0d required %0d 1", name, ce_cnt, ce_rises, lat);
    end
    n_checks++;
    if (first_k != lat + 3 || valid_cycles != 1) begin
      n_fail++;
      $display("FAIL %s_timing rsp_valid_cycle=%0d width=%0d required %0d 1", name, first_k, valid_cycles, lat + 3);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : '1;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_rsp got res=%h flags=%b cmd=%h required res=%h flags=%b cmd=%h",
               name, got.res, got.flags, got.cmd, exp.res, exp.flags, exp.cmd);
    end
  endtask

  task automatic test_burst;
    int max_lvl;
    max_lvl = 0;
    rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          push_req(8'(i * 3 + 1), 8'(i + 2), 1'b0, 1'(i % 2), 4'(i), 2'b11);
      end
      begin
        time t_prev;
        bit ok;
        alu_rsp_t got, exp;
        t_prev = 0;
        for (int j = 0; j < 6; j++) begin
          get_rsp(ok, got);
          exp = (sb.size() > 0) ? sb.pop_front() : '1;
          n_checks++;
          if (!ok || got !== exp) begin
            n_fail++;
            $display("FAIL burst_rsp%0d got res=%h flags=%b cmd=%h required res=%h flags=%b cmd=%h",
                     j, got.res, got.flags, got.cmd, exp.res, exp.flags, exp.cmd);
          end
          if (j > 0) begin
            n_checks++;
            if ($time - t_prev != (LAT + 3) * PERIOD + 0) begin
              n_fail++;
              $display("FAIL burst_spacing%0d got %0t required %0d", j, $time - t_prev, (LAT + 3) * PERIOD);
            end
          end
          t_prev = $time;
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge CLK);
          if (int'(level) > max_lvl) max_lvl = int'(level);
          n_checks++;
          if (req_ready !== (level != DEPTH)) begin
            n_fail++;
            $display("FAIL burst_ready level=%0d req_ready=%b required %b", level, req_ready, level != DEPTH);
          end
        end
      end
    join
    @(posedge CLK); #1;
    n_checks++;
    if (max_lvl != DEPTH || sb.size() != 0) begin
      n_fail++;
      $display("FAIL burst_fill max_level=%0d left=%0d required %0d 0", max_lvl, sb.size(), DEPTH);
    end
  endtask

  task automatic test_backpressure;
    alu_rsp_t held, got, exp;
    bit ok, stable;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_req(8'hA0 + 8'(i), 8'h0F, 1'b0, 1'b0, 4'(i + 1), 2'b11);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLK);
    @(negedge CLK);
    held = '{res: rsp_res, flags: rsp_flags, cmd: rsp_cmd};
    stable = rsp_valid;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      n_checks++;
      if (!stable || rsp_valid !== 1'b1 || {rsp_res, rsp_flags, rsp_cmd} !== held || CE !== 1'b0 || level !== DEPTH) begin
        n_fail++;
        $display("FAIL bp_hold cyc=%0d valid=%b rsp=%h ce=%b level=%0d required 1 %h 0 %0d",
                 c, rsp_valid, {rsp_res, rsp_flags, rsp_cmd}, CE, level, held, DEPTH);
      end
    end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      get_rsp(ok, got);
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      n_checks++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL bp_rsp%0d got res=%h flags=%b cmd=%h required res=%h flags=%b cmd=%h",
                 j, got.res, got.flags, got.cmd, exp.res, exp.flags, exp.cmd);
      end
    end
    n_checks++;
    if (level !== '0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain level=%0d req_ready=%b required 0 1", level, req_ready);
    end
  endtask

  task automatic test_reset_mid_mul;
    rsp_ready = 1'b1;
    push_req(8'h07, 8'h05, 1'b0, 1'b1, CMD_MUL_SHIFT, 2'b11);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    n_checks++;
    if (CE !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_mul_wait CE=%b required 1", CE);
    end
    RST = 1'b0;
    #1;
    n_checks++;
    if ({OPA, OPB, CIN, CE, MODE, INP_VALID, CMD, rsp_valid, rsp_res, rsp_flags, rsp_cmd, level, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL mid_mul_reset got %h required all zero", {OPA, OPB, CIN, CE, MODE, INP_VALID, CMD,
               rsp_valid, rsp_res, rsp_flags, rsp_cmd, level, req_ready});
    end
    sb.delete();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mul_release req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
    test_single_op("post_reset_add", 8'hFF, 8'h01, 1'b0, 1'b1, 4'd0, 2'b11, LAT);
  endtask

  initial begin
    test_reset();
    test_single_op("add", 8'h05, 8'h03, 1'b0, 1'b1, 4'd0, 2'b11, LAT);
    test_single_op("mul", 8'h02, 8'h03, 1'b0, 1'b1, CMD_MUL_INC, 2'b11, MUL_LAT);
    test_burst();
    test_backpressure();
    test_reset_mid_mul();
    test_single_op("inp_valid_00", 8'h10, 8'h20, 1'b0, 1'b1, 4'd0, 2'b00, LAT);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
